// File: rtl/bit_cmd_sched_pkg.sv
// Shared types and constants for the bit command scheduler.
package bitcmd_pkg;

  localparam int SEL_W           = 2;
  localparam int STATE_W         = 4;
  localparam int DEFAULT_TIMEOUT = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/bit_cmd_sched_if.sv
// Requester and datapath signals of the bit command scheduler.
interface bit_cmd_sched_if
  import bitcmd_pkg::*;
#(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       req_val;
  logic [SEL_W*N_REQ-1:0] req_sel;
  logic [N_REQ-1:0]       gnt;
  logic                   done;
  logic [ID_W-1:0]        done_id;
  logic                   noop;
  logic                   err;
  logic                   busy;
  logic                   fsm_en;
  logic                   fsm_val;
  logic [SEL_W-1:0]       fsm_sel;
  logic [STATE_W-1:0]     fsm_state;

  modport master (
    output req, req_val, req_sel, fsm_state,
    input  gnt, done, done_id, noop, err, busy, fsm_en, fsm_val, fsm_sel
  );

  modport slave (
    input  req, req_val, req_sel, fsm_state,
    output gnt, done, done_id, noop, err, busy, fsm_en, fsm_val, fsm_sel
  );

endinterface

// File: rtl/bit_cmd_sched_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         win,
  output logic                     valid
);

  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] first;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, then rotate back.
  always_comb begin
    rot   = N_REQ'({req, req} >> ptr);
    first = rot & (~rot + {{(N_REQ-1){1'b0}}, 1'b1});
    win   = N_REQ'(({first, first} << ptr) >> N_REQ);
    valid = |req;
  end

endmodule

// File: rtl/bit_cmd_sched.sv
// Round-robin scheduler granting requesters one at a time to the 4-bit set/clear datapath.
// Optional WAIT timeout enabled by defining BITCMD_TIMEOUT_EN.
module bit_cmd_sched
  import bitcmd_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  bit_cmd_sched_if.slave  bus
);

  localparam int ID_W = $clog2(N_REQ);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   ptr_next;
  logic [SEL_W-1:0]  sel_q;
  logic              val_q;
  logic              noop_q;
  logic [N_REQ-1:0]  win;
  logic              win_valid;
  logic              hit;
  logic              timeout_hit;
  logic              err_flag;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (bus.req),
    .ptr   (ptr_q),
    .win   (win),
    .valid (win_valid)
  );

  always_comb begin
    win_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) win_id = ID_W'(i);
    end
  end

  assign ptr_next = (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + 1'b1;
  assign hit      = (bus.fsm_state[sel_q] == val_q);

`ifdef BITCMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT+1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // The counter restarts in ISSUE so the first WAIT cycle counts as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == ISSUE)     cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + 1'b1;
      if (state_q == IDLE)                               err_q <= 1'b0;
      else if (state_q == WAIT && !hit && timeout_hit)   err_q <= 1'b1;
    end
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT-1));
  assign err_flag    = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_flag    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      val_q   <= 1'b0;
      sel_q   <= '0;
      noop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            id_q   <= win_id;
            val_q  <= bus.req_val[win_id];
            sel_q  <= bus.req_sel[{win_id, 1'b0} +: SEL_W];
            ptr_q  <= ptr_next;
            noop_q <= 1'b0;
          end
        end
        CHECK:   noop_q <= hit;
        default: ;
      endcase
    end
  end

  // Outputs decode only registered state, so req never reaches gnt combinationally.
  always_comb begin
    state_d     = state_q;
    bus.gnt     = '0;
    bus.done    = 1'b0;
    bus.done_id = '0;
    bus.noop    = 1'b0;
    bus.err     = 1'b0;
    bus.busy    = (state_q != IDLE);
    bus.fsm_en  = 1'b0;
    bus.fsm_val = 1'b0;
    bus.fsm_sel = '0;

    if (state_q != IDLE) begin
      bus.fsm_val = val_q;
      bus.fsm_sel = sel_q;
    end

    case (state_q)
      IDLE: begin
        if (win_valid) state_d = CHECK;
      end
      CHECK: begin
        bus.gnt[id_q] = 1'b1;
        state_d       = hit ? DONE : ISSUE;
      end
      ISSUE: begin
        bus.fsm_en = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (hit || timeout_hit) state_d = DONE;
      end
      DONE: begin
        bus.done    = 1'b1;
        bus.done_id = id_q;
        bus.noop    = noop_q;
        bus.err     = err_flag;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bit_cmd_sched.sv
// Directed self-checking bench for bit_cmd_sched with a simple 4-bit datapath model.
module tb_bit_cmd_sched;

  localparam int N_REQ = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dp;
  logic [3:0] load_val;
  logic       load;
  logic       freeze;
  int         tests_run = 0;
  int         tests_failed = 0;

  always #5 clk = ~clk;

  bit_cmd_sched_if #(.N_REQ(N_REQ)) bus ();

  bit_cmd_sched #(.N_REQ(N_REQ), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Datapath model: resets with the scheduler, can be preloaded or frozen.
  always @(posedge clk) begin
    if (rst)                         dp <= 4'b0000;
    else if (load)                   dp <= load_val;
    else if (bus.fsm_en && !freeze)  dp[bus.fsm_sel] <= bus.fsm_val;
  end

  assign bus.fsm_state = dp;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    rst         = 1'b1;
    bus.req     = '0;
    bus.req_val = '0;
    bus.req_sel = '0;
    load        = 1'b0;
    load_val    = 4'b0000;
    freeze      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_dp(input logic [3:0] v);
    load_val = v;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] s);
    bus.req[i]          = 1'b1;
    bus.req_val[i]      = v;
    bus.req_sel[2*i+:2] = s;
  endtask

  task automatic test_reset;
    logic [7:0] obs;
    rst         = 1'b1;
    bus.req     = 4'b1111;
    bus.req_val = 4'b1010;
    bus.req_sel = 8'hE4;
    load        = 1'b0;
    load_val    = 4'b0000;
    freeze      = 1'b0;
    tick();
    tick();
    obs = {bus.gnt, bus.busy, bus.fsm_en, bus.done, bus.err};
    tests_run++;
    if (obs !== 8'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got %b expected %b", obs, 8'b0);
    end
    tests_run++;
    if ({bus.fsm_val, bus.fsm_sel, bus.noop, bus.done_id} !== 6'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_cmd: got %b expected %b",
               {bus.fsm_val, bus.fsm_sel, bus.noop, bus.done_id}, 6'b0);
    end
    rst     = 1'b0;
    bus.req = '0;
    tick();
  endtask

  task automatic test_single_command;
    logic [7:0] obs, want;
    reset_dut();
    load_dp(4'b0000);
    set_req(0, 1'b1, 2'd2);
    for (int c = 1; c <= 5; c++) begin
      tick();
      obs  = {bus.gnt, bus.busy, bus.fsm_en, bus.done, bus.err};
      want = {(c == 1) ? 4'b0001 : 4'b0000, c <= 4, c == 2, c == 4, 1'b0};
      tests_run++;
      if (obs !== want) begin
        tests_failed++;
        $display("[TB] FAIL single_c%0d: got %b expected %b", c, obs, want);
      end
      if (c == 1) bus.req[0] = 1'b0;
      if (c == 2) begin
        tests_run++;
        if ({bus.fsm_sel, bus.fsm_val} !== 3'b101) begin
          tests_failed++;
          $display("[TB] FAIL single_cmd: got %b expected %b", {bus.fsm_sel, bus.fsm_val}, 3'b101);
        end
      end
      if (c == 4) begin
        tests_run++;
        if ({bus.done_id, bus.noop} !== 3'b000) begin
          tests_failed++;
          $display("[TB] FAIL single_done: got %b expected %b", {bus.done_id, bus.noop}, 3'b000);
        end
      end
    end
    tests_run++;
    if (dp !== 4'b0100) begin
      tests_failed++;
      $display("[TB] FAIL single_dp: got %b expected %b", dp, 4'b0100);
    end
  endtask

  task automatic test_noop;
    logic [7:0] obs, want;
    load_dp(4'b0100);
    set_req(1, 1'b1, 2'd2);
    for (int c = 1; c <= 4; c++) begin
      tick();
      obs  = {bus.gnt, bus.busy, bus.fsm_en, bus.done, bus.err};
      want = {(c == 1) ? 4'b0010 : 4'b0000, c <= 2, 1'b0, c == 2, 1'b0};
      tests_run++;
      if (obs !== want) begin
        tests_failed++;
        $display("[TB] FAIL noop_c%0d: got %b expected %b", c, obs, want);
      end
      if (c == 1) bus.req[1] = 1'b0;
      if (c == 2) begin
        tests_run++;
        if ({bus.done_id, bus.noop} !== 3'b011) begin
          tests_failed++;
          $display("[TB] FAIL noop_done: got %b expected %b", {bus.done_id, bus.noop}, 3'b011);
        end
      end
    end
  endtask

  task automatic test_round_robin;
    logic [7:0] obs, want;
    logic [3:0] eg;
    reset_dut();
    load_dp(4'b0100);
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 2'd2);
    for (int c = 1; c <= 13; c++) begin
      tick();
      eg   = (c % 3 == 1) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
      obs  = {bus.gnt, bus.busy, bus.fsm_en, bus.done, bus.err};
      want = {eg, c % 3 != 0, 1'b0, c % 3 == 2, 1'b0};
      tests_run++;
      if (obs !== want) begin
        tests_failed++;
        $display("[TB] FAIL rr_c%0d: got %b expected %b", c, obs, want);
      end
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_wait;
    logic [7:0] obs, want;
    reset_dut();
    load_dp(4'b0000);
    freeze = 1'b1;
    set_req(1, 1'b1, 2'd0);
    tick();
    bus.req[1] = 1'b0;
    tick();
    tick();
    tick();
    tests_run++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL midwait_stuck: got %b expected %b", {bus.busy, bus.done}, 2'b10);
    end
    rst = 1'b1;
    tick();
    obs = {bus.gnt, bus.busy, bus.fsm_en, bus.done, bus.err};
    tests_run++;
    if (obs !== 8'b0) begin
      tests_failed++;
      $display("[TB] FAIL midwait_reset: got %b expected %b", obs, 8'b0);
    end
    rst    = 1'b0;
    freeze = 1'b0;
    set_req(1, 1'b0, 2'd0);
    set_req(3, 1'b0, 2'd0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      obs  = {bus.gnt, bus.busy, bus.fsm_en, bus.done, bus.err};
      want = {(c == 1) ? 4'b0010 : (c == 4) ? 4'b1000 : 4'b0000, c != 3, 1'b0, c == 2, 1'b0};
      tests_run++;
      if (obs !== want) begin
        tests_failed++;
        $display("[TB] FAIL midwait_after_c%0d: got %b expected %b", c, obs, want);
      end
      if (c == 1) bus.req[1] = 1'b0;
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back;
    logic [7:0] obs, want;
    logic [3:0] eg;
    reset_dut();
    load_dp(4'b0000);
    set_req(0, 1'b1, 2'd0);
    set_req(1, 1'b1, 2'd1);
    for (int c = 1; c <= 10; c++) begin
      tick();
      eg   = (c == 1) ? 4'b0001 : (c == 6) ? 4'b0010 : 4'b0000;
      obs  = {bus.gnt, bus.busy, bus.fsm_en, bus.done, bus.err};
      want = {eg, c != 5 && c != 10, c == 2 || c == 7, c == 4 || c == 9, 1'b0};
      tests_run++;
      if (obs !== want) begin
        tests_failed++;
        $display("[TB] FAIL b2b_c%0d: got %b expected %b", c, obs, want);
      end
      if (c == 1) bus.req[0] = 1'b0;
      if (c == 6) bus.req[1] = 1'b0;
      if (c == 9) begin
        tests_run++;
        if ({bus.done_id, bus.noop} !== 3'b010) begin
          tests_failed++;
          $display("[TB] FAIL b2b_done2: got %b expected %b", {bus.done_id, bus.noop}, 3'b010);
        end
      end
    end
    tests_run++;
    if (dp !== 4'b0011) begin
      tests_failed++;
      $display("[TB] FAIL b2b_dp: got %b expected %b", dp, 4'b0011);
    end
  endtask

  task automatic test_drop_request;
    logic [7:0] obs, want;
    logic [3:0] eg;
    reset_dut();
    load_dp(4'b0100);
    set_req(0, 1'b1, 2'd2);
    set_req(2, 1'b1, 2'd2);
    set_req(3, 1'b1, 2'd2);
    for (int c = 1; c <= 7; c++) begin
      tick();
      eg   = (c == 1 || c == 7) ? 4'b0001 : (c == 4) ? 4'b1000 : 4'b0000;
      obs  = {bus.gnt, bus.busy, bus.fsm_en, bus.done, bus.err};
      want = {eg, c % 3 != 0, 1'b0, c % 3 == 2, 1'b0};
      tests_run++;
      if (obs !== want) begin
        tests_failed++;
        $display("[TB] FAIL drop_c%0d: got %b expected %b", c, obs, want);
      end
      if (c == 1) bus.req[2] = 1'b0;
    end
    bus.req = '0;
    tick();
    tick();
  endtask

`ifdef BITCMD_TIMEOUT_EN
  task automatic test_timeout;
    logic [7:0] obs, want;
    reset_dut();
    load_dp(4'b0000);
    freeze = 1'b1;
    set_req(0, 1'b1, 2'd3);
    for (int c = 1; c <= 12; c++) begin
      tick();
      obs  = {bus.gnt, bus.busy, bus.fsm_en, bus.done, bus.err};
      want = {(c == 1) ? 4'b0001 : 4'b0000, c <= 11, c == 2, c == 11, c == 11};
      tests_run++;
      if (obs !== want) begin
        tests_failed++;
        $display("[TB] FAIL timeout_c%0d: got %b expected %b", c, obs, want);
      end
      if (c == 1) bus.req[0] = 1'b0;
      if (c == 11) begin
        tests_run++;
        if (bus.noop !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL timeout_noop: got %b expected %b", bus.noop, 1'b0);
        end
      end
    end
    freeze = 1'b0;
  endtask
`else
  task automatic test_wait_unbounded;
    logic [7:0] obs, want;
    reset_dut();
    load_dp(4'b0000);
    freeze = 1'b1;
    set_req(0, 1'b1, 2'd3);
    for (int c = 1; c <= 20; c++) begin
      tick();
      obs  = {bus.gnt, bus.busy, bus.fsm_en, bus.done, bus.err};
      want = {(c == 1) ? 4'b0001 : 4'b0000, 1'b1, c == 2, 1'b0, 1'b0};
      tests_run++;
      if (obs !== want) begin
        tests_failed++;
        $display("[TB] FAIL unbounded_c%0d: got %b expected %b", c, obs, want);
      end
      if (c == 1) bus.req[0] = 1'b0;
    end
    freeze = 1'b0;
    reset_dut();
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_command();
    test_noop();
    test_round_robin();
    test_reset_mid_wait();
    test_back_to_back();
    test_drop_request();
`ifdef BITCMD_TIMEOUT_EN
    test_timeout();
`else
    test_wait_unbounded();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
